// File: rtl/rv32im_writeback_stage_if.sv
// Divider-to-write-back handshake: result offer from the divider, ready back from the
// one-entry pending buffer.
interface rv32im_writeback_stage_if #(
    parameter int unsigned WIDTH = 32
);
    logic             i_div_valid;
    logic [4:0]       i_div_rd;
    logic [WIDTH-1:0] i_div_result;
    logic             o_div_ready;

    modport master (
        output i_div_valid,
        output i_div_rd,
        output i_div_result,
        input  o_div_ready
    );

    modport slave (
        input  i_div_valid,
        input  i_div_rd,
        input  i_div_result,
        output o_div_ready
    );
endinterface

// File: rtl/rv32im_writeback_stage.sv
// Registered RV32IM write-back stage: source select, load alignment/extension, and merge of
// out-of-order divider results through a one-entry pending buffer with forced drain.
module rv32im_writeback_stage #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_valid,
    input  logic [6:0]                  i_opcode,
    input  logic [2:0]                  i_funct3,
    input  logic [6:0]                  i_funct7,
    input  logic [4:0]                  i_rd,
    input  logic [WIDTH-1:0]            i_alu_result,
    input  logic [WIDTH-1:0]            i_mem_data,
    input  logic [WIDTH-1:0]            pc,
    rv32im_writeback_stage_if.slave     div_if,
    output logic                        o_stall,
    output logic                        o_wb_en,
    output logic [4:0]                  o_wb_rd,
    output logic [WIDTH-1:0]            o_wb_data
);

    localparam int unsigned OFFW = $clog2(WIDTH / 8);
    localparam int unsigned CNTW = $clog2(MAX_WAIT + 1);
    localparam logic [CNTW-1:0] MaxCnt = CNTW'(MAX_WAIT);

    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpImm   = 7'b0010011;
    localparam logic [6:0] OpReg   = 7'b0110011;
    localparam logic [6:0] OpLui   = 7'b0110111;
    localparam logic [6:0] OpAuipc = 7'b0010111;
    localparam logic [6:0] OpJal   = 7'b1101111;
    localparam logic [6:0] OpJalr  = 7'b1100111;

    logic             r_pend_valid;
    logic [4:0]       r_pend_rd;
    logic [WIDTH-1:0] r_pend_data;
    logic [CNTW-1:0]  r_wait_cnt;
    logic             r_wb_en;
    logic [4:0]       r_wb_rd;
    logic [WIDTH-1:0] r_wb_data;

    logic             w_pend_valid_d;
    logic [4:0]       w_pend_rd_d;
    logic [WIDTH-1:0] w_pend_data_d;
    logic [CNTW-1:0]  w_wait_cnt_d;
    logic             w_wb_en_d;
    logic [4:0]       w_wb_rd_d;
    logic [WIDTH-1:0] w_wb_data_d;

    logic             w_is_div;
    logic             w_writes_rd;
    logic             w_pw;
    logic             w_capture;
    logic [OFFW-1:0]  w_off;
    logic [OFFW-1:0]  w_off_sel;
    logic [WIDTH-1:0] w_shift;
    logic [WIDTH-1:0] w_load;
    logic [WIDTH-1:0] w_pipe_data;

    assign w_is_div = (i_opcode == OpReg) && (i_funct7 == 7'b0000001) && i_funct3[2];

    always_comb begin
        w_writes_rd = 1'b0;
        case (i_opcode)
            OpLoad, OpImm, OpReg, OpLui, OpAuipc, OpJal, OpJalr: w_writes_rd = 1'b1;
            default:                                             w_writes_rd = 1'b0;
        endcase
    end

    assign o_stall = r_pend_valid && (r_wait_cnt == MaxCnt);
    assign w_pw    = i_valid && !o_stall && w_writes_rd && (i_rd != 5'd0) && !w_is_div;

    // Pipeline instruction is younger than any divider result, so it wins a same-rd race.
    assign w_capture = div_if.i_div_valid && !r_pend_valid && (div_if.i_div_rd != 5'd0) &&
                       !(w_pw && (i_rd == div_if.i_div_rd));
    assign div_if.o_div_ready = !r_pend_valid;

    always_comb begin
        w_off     = i_alu_result[OFFW-1:0];
        w_off_sel = w_off;
        case (i_funct3[1:0])
            2'b01:   w_off_sel = w_off & ~OFFW'(1);
            2'b10:   w_off_sel = w_off & ~OFFW'(3);
            2'b11:   w_off_sel = '0;
            default: w_off_sel = w_off;
        endcase
        w_shift = i_mem_data >> {w_off_sel, 3'b000};

        w_load = '0;
        case (i_funct3)
            3'b000: w_load = WIDTH'($signed(w_shift[7:0]));
            3'b001: w_load = WIDTH'($signed(w_shift[15:0]));
            3'b010: w_load = WIDTH'($signed(w_shift[31:0]));
            3'b011: if (WIDTH == 64) w_load = w_shift;
            3'b100: w_load = WIDTH'(w_shift[7:0]);
            3'b101: w_load = WIDTH'(w_shift[15:0]);
            3'b110: if (WIDTH == 64) w_load = WIDTH'(w_shift[31:0]);
            default: w_load = '0;
        endcase
    end

    always_comb begin
        case (i_opcode)
            OpLoad:        w_pipe_data = w_load;
            OpJal, OpJalr: w_pipe_data = pc + WIDTH'(4);
            default:       w_pipe_data = i_alu_result;
        endcase
    end

    always_comb begin
        w_wb_en_d      = 1'b0;
        w_wb_rd_d      = r_wb_rd;
        w_wb_data_d    = r_wb_data;
        w_pend_valid_d = r_pend_valid;
        w_pend_rd_d    = r_pend_rd;
        w_pend_data_d  = r_pend_data;
        w_wait_cnt_d   = r_wait_cnt;

        if (o_stall) begin
            w_wb_en_d      = 1'b1;
            w_wb_rd_d      = r_pend_rd;
            w_wb_data_d    = r_pend_data;
            w_pend_valid_d = 1'b0;
            w_wait_cnt_d   = '0;
        end else if (w_pw) begin
            w_wb_en_d   = 1'b1;
            w_wb_rd_d   = i_rd;
            w_wb_data_d = w_pipe_data;
            if (r_pend_valid) begin
                if (r_pend_rd == i_rd) begin
                    w_pend_valid_d = 1'b0;
                    w_wait_cnt_d   = '0;
                end else if (r_wait_cnt < MaxCnt) begin
                    w_wait_cnt_d = r_wait_cnt + CNTW'(1);
                end
            end
        end else if (r_pend_valid) begin
            w_wb_en_d      = 1'b1;
            w_wb_rd_d      = r_pend_rd;
            w_wb_data_d    = r_pend_data;
            w_pend_valid_d = 1'b0;
            w_wait_cnt_d   = '0;
        end

        // Capture only happens with an empty buffer, so it never collides with a drain.
        if (w_capture) begin
            w_pend_valid_d = 1'b1;
            w_pend_rd_d    = div_if.i_div_rd;
            w_pend_data_d  = div_if.i_div_result;
            w_wait_cnt_d   = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pend_valid <= 1'b0;
            r_pend_rd    <= '0;
            r_pend_data  <= '0;
            r_wait_cnt   <= '0;
            r_wb_en      <= 1'b0;
            r_wb_rd      <= '0;
            r_wb_data    <= '0;
        end else begin
            r_pend_valid <= w_pend_valid_d;
            r_pend_rd    <= w_pend_rd_d;
            r_pend_data  <= w_pend_data_d;
            r_wait_cnt   <= w_wait_cnt_d;
            r_wb_en      <= w_wb_en_d;
            r_wb_rd      <= w_wb_rd_d;
            r_wb_data    <= w_wb_data_d;
        end
    end

    assign o_wb_en   = r_wb_en;
    assign o_wb_rd   = r_wb_rd;
    assign o_wb_data = r_wb_data;

endmodule
